cp0_regfile: RTL and testbench

- Coprocessor-0 register file. It sources the Status/Cause/EPC values consumed by the exception decoder and commits the exception type that decoder produces.
- Sits in the MEM stage. On an exception it updates EPC/Cause/Status/BadVAddr. On ERET it clears EXL.
- Also owns the Count/Compare timer and provides MFC0 read and MTC0 write access.

---
 rtl/cp0_regfile_pkg.sv | 48 ++++
 rtl/cp0_regfile_timer.sv | 41 ++++
 rtl/cp0_regfile.sv | 107 ++++++++++
 tb/tb_cp0_regfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, committed exception codes,
// register field positions and the exception classification helper.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000A;
  localparam logic [31:0] EXC_OV   = 32'h0000_000C;
  localparam logic [31:0] EXC_TR   = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET = 32'h0000_000E;

  localparam int EXL_BIT    = 1;
  localparam int IE_BIT     = 0;
  localparam int BD_BIT     = 31;
  localparam int IP_HI      = 15;
  localparam int IP_LO      = 8;
  localparam int EXCCODE_HI = 6;
  localparam int EXCCODE_LO = 2;

  localparam logic [31:0] CP0_STATUS_RST = 32'h0040_0000;

  typedef enum logic [1:0] {
    EXC_CLASS_NONE,
    EXC_CLASS_RECORD,
    EXC_CLASS_ERET
  } exc_class_t;

  // Unknown nonzero codes classify as NONE: they leave the register file untouched.
  function automatic exc_class_t classify_exc(input logic [31:0] code);
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP,
      EXC_RI, EXC_OV, EXC_TR:                      return EXC_CLASS_RECORD;
      EXC_ERET:                                    return EXC_CLASS_ERET;
      default:                                     return EXC_CLASS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances every second cycle, and a match against
// a nonzero Compare latches a sticky interrupt until Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= 1'b0;
      count     <= 32'd0;
      compare   <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        tick  <= 1'b0;
      end else begin
        tick <= ~tick;
        if (tick) count <= count + 32'd1;
      end

      // A Compare write clears the pending flag; any match it creates is seen next cycle.
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((count == compare) && (compare != 32'd0)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MFC0/MTC0 access, exception/ERET commit into
// Status/Cause/EPC/BadVAddr, and the Count/Compare timer interrupt.
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] STATUS_RST   = CP0_STATUS_RST,
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype,
  input  logic [31:0] cur_pc,
  input  logic        in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  exc_class_t  exc_class;
  logic        mtc0;
  logic        is_addr_exc;

  assign exc_class   = classify_exc(excepttype);
  assign is_addr_exc = (excepttype == EXC_ADEL) || (excepttype == EXC_ADES);
  // Any committed exception squashes the MTC0 issued alongside it.
  assign mtc0        = we && (excepttype == 32'd0);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0 && (waddr == REG_COUNT)),
    .compare_we (mtc0 && (waddr == REG_COMPARE)),
    .wdata      (wdata),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= STATUS_RST;
      cause    <= 32'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
    end else begin
      cause[IP_HI:IP_LO+2] <= {int_i[5] | timer_int_o, int_i[4:0]};

      if (mtc0) begin
        case (waddr)
          REG_STATUS: status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
          REG_CAUSE:  cause[IP_LO+1:IP_LO] <= wdata[IP_LO+1:IP_LO];
          REG_EPC:    epc <= wdata;
          default:    ;
        endcase
      end

      case (exc_class)
        EXC_CLASS_RECORD: begin
          // Nested exceptions keep the original return point.
          if (!status[EXL_BIT]) begin
            epc           <= in_delayslot ? (cur_pc - 32'd4) : cur_pc;
            cause[BD_BIT] <= in_delayslot;
          end
          status[EXL_BIT]                 <= 1'b1;
          cause[EXCCODE_HI:EXCCODE_LO]    <= (excepttype == EXC_INT) ? 5'd0 : excepttype[4:0];
          if (is_addr_exc) badvaddr <= bad_addr;
        end
        EXC_CLASS_ERET: status[EXL_BIT] <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count_o;
      REG_COMPARE:  rdata = compare_o;
      REG_STATUS:   rdata = status;
      REG_CAUSE:    rdata = cause;
      REG_EPC:      rdata = epc;
      default:      rdata = 32'd0;
    endcase
  end

  assign status_o   = status;
  assign cause_o    = cause;
  assign epc_o      = epc;
  assign badvaddr_o = badvaddr;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed walk through the main scenarios, then
// randomized traffic compared every cycle against a behavioural model.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  int_i;
  logic [31:0] excepttype;
  logic [31:0] cur_pc;
  logic        in_delayslot;
  logic [31:0] bad_addr;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .int_i        (int_i),
    .excepttype   (excepttype),
    .cur_pc       (cur_pc),
    .in_delayslot (in_delayslot),
    .bad_addr     (bad_addr),
    .status_o     (status_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .badvaddr_o   (badvaddr_o),
    .timer_int_o  (timer_int_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Count is kept as (value last loaded) + (cycles since load)/2.
  logic [31:0] m_status, m_cause, m_epc, m_compare, m_badvaddr, m_count_base;
  int unsigned m_cycles;
  logic        m_pend;
  logic [192:0] exp_q[$];

  always @(posedge clk) begin : model
    logic [31:0] cnt;
    logic        match, wr, old_pend;
    if (rst) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_compare = 0;
      m_badvaddr = 0; m_count_base = 0; m_cycles = 0; m_pend = 0;
    end else begin
      cnt      = m_count_base + 32'(m_cycles / 2);
      match    = (cnt == m_compare) && (m_compare != 0);
      old_pend = m_pend;
      wr       = we && (excepttype == 0);
      if (wr && waddr == 9) begin m_count_base = wdata; m_cycles = 0; end
      else m_cycles++;
      if (wr && waddr == 11) begin m_compare = wdata; m_pend = 0; end
      else if (match) m_pend = 1;
      m_cause[15:10] = {int_i[5] | old_pend, int_i[4:0]};
      if (wr && waddr == 12) m_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
      if (wr && waddr == 13) m_cause[9:8] = wdata[9:8];
      if (wr && waddr == 14) m_epc = wdata;
      if (excepttype inside {1, 4, 5, 8, 9, 10, 12, 13}) begin
        if (m_status[1] == 0) begin
          m_epc = in_delayslot ? cur_pc - 4 : cur_pc;
          m_cause[31] = in_delayslot;
        end
        m_status[1] = 1;
        m_cause[6:2] = (excepttype == 1) ? 5'd0 : excepttype[4:0];
        if (excepttype == 4 || excepttype == 5) m_badvaddr = bad_addr;
      end else if (excepttype == 14) begin
        m_status[1] = 0;
      end
    end
    exp_q.push_back({m_status, m_cause, m_epc, m_count_base + 32'(m_cycles / 2),
                     m_compare, m_badvaddr, m_pend});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [192:0] e;
    logic [31:0]  es, ec, ee, ecnt, ecmp, ebv, erd;
    logic         et;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {es, ec, ee, ecnt, ecmp, ebv, et} = e;
      case (raddr)
        5'd8:  erd = ebv;
        5'd9:  erd = ecnt;
        5'd11: erd = ecmp;
        5'd12: erd = es;
        5'd13: erd = ec;
        5'd14: erd = ee;
        default: erd = 0;
      endcase
      check("status", status_o, es);
      check("cause", cause_o, ec);
      check("epc", epc_o, ee);
      check("count", count_o, ecnt);
      check("compare", compare_o, ecmp);
      check("badvaddr", badvaddr_o, ebv);
      check("timer_int", {31'd0, timer_int_o}, {31'd0, et});
      check("rdata", rdata, erd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    we = 0; excepttype = 0; in_delayslot = 0;
    repeat (n) step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
  endtask

  task automatic commit(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] ba);
    excepttype = code; cur_pc = pc; in_delayslot = ds; bad_addr = ba;
    step();
    excepttype = 0; in_delayslot = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    logic [31:0] codes[12];
    codes = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hD, 32'hE, 32'h3, 32'h7, 32'hF};
    rst = 1; we = 0; waddr = 0; wdata = 0; raddr = 0; int_i = 0;
    excepttype = 0; cur_pc = 0; in_delayslot = 0; bad_addr = 0;
    step(); step();
    rst = 0;
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_count", count_o, 32'h0);
    check("rst_timer", {31'd0, timer_int_o}, 32'h0);

    idle(10);
    check("idle10_count", count_o, 32'd5);
    check("idle10_status", status_o, 32'h0040_0000);

    mtc0(5'd11, 32'd8);
    n = 0;
    while (!timer_int_o && n < 40) begin step(); n++; end
    check("timer_rise_latency", 32'(n), 32'd6);
    check("timer_rise_count", count_o, 32'd8);
    step();
    check("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd0);
    check("timer_clear", {31'd0, timer_int_o}, 32'd0);

    commit(32'hC, 32'hBFC0_0100, 1'b1, 32'h0);
    check("ov_epc", epc_o, 32'hBFC0_00FC);
    check("ov_bd", {31'd0, cause_o[31]}, 32'd1);
    check("ov_exccode", {27'd0, cause_o[6:2]}, 32'h0C);
    check("ov_exl", {31'd0, status_o[1]}, 32'd1);

    commit(32'h4, 32'hBFC0_0200, 1'b0, 32'h0000_0003);
    check("adel_epc_kept", epc_o, 32'hBFC0_00FC);
    check("adel_badvaddr", badvaddr_o, 32'h0000_0003);
    check("adel_exccode", {27'd0, cause_o[6:2]}, 32'h04);

    we = 1; waddr = 5'd14; wdata = 32'h1234_5678;
    commit(32'hE, 32'h0, 1'b0, 32'h0);
    we = 0;
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);
    check("eret_epc_kept", epc_o, 32'hBFC0_00FC);

    mtc0(5'd12, 32'hFFFF_FFFF);
    check("status_wmask", status_o, 32'h0040_FF03);
    raddr = 5'd12; #1;
    check("mfc0_status", rdata, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_wmask", cause_o, 32'h8000_0310);
    raddr = 5'd5; #1;
    check("mfc0_unmapped", rdata, 32'h0);

    mtc0(5'd9, 32'hFFFF_FFFF);
    check("count_load", count_o, 32'hFFFF_FFFF);
    idle(2);
    check("count_wrap", count_o, 32'h0);

    repeat (1500) begin
      rst = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: waddr = 5'd8;
        1: waddr = 5'd9;
        2: waddr = 5'd11;
        3: waddr = 5'd12;
        4: waddr = 5'd13;
        5: waddr = 5'd14;
        default: waddr = 5'($urandom_range(0, 31));
      endcase
      wdata = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
      excepttype = ($urandom_range(0, 19) < 12) ? 32'h0 : codes[$urandom_range(0, 11)];
      raddr = 5'($urandom_range(0, 31));
      int_i = 6'($urandom_range(0, 63));
      cur_pc = $urandom;
      in_delayslot = 1'($urandom_range(0, 1));
      bad_addr = $urandom;
      step();
    end
    rst = 0;
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
